dram_read_arbiter: RTL and testbench

- Shares one DRAMReader instance (one config port plus one 64-bit read stream) between two requesters, e.g. a frame fetcher and a line-buffer refill engine.
- Accepts one job (start address, byte count) per requester and grants round-robin.
- Issues exactly one CONFIG handshake to the reader for each granted job, then steers the reader's data stream to the granted requester until every beat of the job has been delivered.

---
 rtl/dram_read_arbiter_pkg.sv | 13 +
 rtl/dram_read_arbiter_rr_arb2.sv | 17 +
 rtl/dram_read_arbiter.sv | 107 ++++++++++
 tb/tb_dram_read_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_read_arbiter_pkg.sv
// dram_pkg: shared constants, FSM state and job record for dram_read_arbiter
package dram_pkg;
  localparam int BURST_BYTES = 128;
  localparam int BEAT_BYTES = 8;
  localparam int BEATS_PER_BURST = BURST_BYTES / BEAT_BYTES;
  localparam int BEAT_SHIFT = 3;
  localparam int JOB_W = 32;
  typedef enum logic [1:0] {IDLE, CFG, STREAM} state_e;
  typedef struct packed {
    logic [JOB_W-1:0] addr;
    logic [JOB_W-1:0] nbytes;
  } job_t;
endpackage

// File: rtl/dram_read_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; requester 0 wins first after reset
//   req_i: requests, en_i: decision allowed, gnt_o: one-hot grant, upd_o: a grant was made
module rr_arb2 (
  input  logic       ACLK,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       upd_o
);
  logic last_q;
  always_comb gnt_o = !en_i ? 2'b00 : &req_i ? (last_q ? 2'b01 : 2'b10) : req_i;
  assign upd_o = |gnt_o;
  always_ff @(posedge ACLK or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else if (upd_o) last_q <= gnt_o[1];
endmodule

// File: rtl/dram_read_arbiter.sv
// dram_read_arbiter: shares one DRAM reader (config port + read stream) between two requesters
//   req*_*: job request (addr, nbytes) with ready pulse on grant; done*: job-complete pulse
//   out*_*: per-requester stream; CONFIG_*: reader config port; rd_dout*: reader stream
module dram_read_arbiter
  import dram_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BURST_SHIFT = 7
) (
  input  logic              ACLK,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [ADDR_W-1:0] req0_nbytes,
  input  logic [ADDR_W-1:0] req1_nbytes,
  output logic              done0,
  output logic              done1,
  output logic              out0_valid,
  output logic              out1_valid,
  input  logic              out0_ready,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [DATA_W-1:0] out1_data,
  output logic              CONFIG_VALID,
  input  logic              CONFIG_READY,
  output logic [ADDR_W-1:0] CONFIG_START_ADDR,
  output logic [ADDR_W-1:0] CONFIG_NBYTES,
  input  logic              rd_dout_valid,
  output logic              rd_dout_ready,
  input  logic [DATA_W-1:0] rd_dout
);
  localparam int CNT_W = ADDR_W - BEAT_SHIFT;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << BURST_SHIFT) - 1);
  state_e state_q;
  logic grant_q, cfg_valid_q, en, upd, sel, streaming, fire;
  logic [1:0] gnt, done_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [ADDR_W-1:0] req_addr, req_nb;
  job_t job_q;
  // rst_n gates the decision so no ready leaks out while reset is held
  assign en = rst_n && state_q == IDLE && CONFIG_READY;
  rr_arb2 u_arb (
    .ACLK  (ACLK),
    .rst_n (rst_n),
    .req_i ({req1_valid, req0_valid}),
    .en_i  (en),
    .gnt_o (gnt),
    .upd_o (upd)
  );
  assign sel = gnt[1];
  assign req_addr = sel ? req1_addr : req0_addr;
  // whole bursts only: the reader cannot do partial bursts
  assign req_nb = (sel ? req1_nbytes : req0_nbytes) & ~LOW_MASK;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign streaming = state_q == STREAM;
  assign out0_valid = streaming && !grant_q && rd_dout_valid;
  assign out1_valid = streaming && grant_q && rd_dout_valid;
  assign rd_dout_ready = streaming && (grant_q ? out1_ready : out0_ready);
  assign fire = rd_dout_valid && rd_dout_ready;
  assign out0_data = rd_dout;
  assign out1_data = rd_dout;
  assign CONFIG_VALID = cfg_valid_q;
  assign CONFIG_START_ADDR = job_q.addr;
  assign CONFIG_NBYTES = job_q.nbytes;
  assign done0 = done_q[0];
  assign done1 = done_q[1];
  always_ff @(posedge ACLK or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      beat_cnt_q <= '0;
      job_q <= '0;
      cfg_valid_q <= 1'b0;
      done_q <= 2'b00;
    end else begin
      cfg_valid_q <= 1'b0;
      done_q <= 2'b00;
      case (state_q)
        IDLE: if (upd) begin
          grant_q <= sel;
          job_q <= '{addr: req_addr, nbytes: req_nb};
          beat_cnt_q <= req_nb[ADDR_W-1:BEAT_SHIFT];
          // sub-burst jobs never reach the reader: its burst counter would wrap
          if (req_nb == '0) done_q <= gnt;
          else begin
            cfg_valid_q <= 1'b1;
            state_q <= CFG;
          end
        end
        CFG: state_q <= STREAM;
        STREAM: if (fire) begin
          beat_cnt_q <= beat_cnt_q - CNT_W'(1);
          if (beat_cnt_q == CNT_W'(1)) begin
            done_q[grant_q] <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dram_read_arbiter.sv
// tb_dram_read_arbiter: directed + random jobs against a reader model and a job-level scoreboard
module tb_dram_read_arbiter;
  logic ACLK, rst_n;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_addr, req1_addr, req0_nbytes, req1_nbytes;
  logic done0, done1, out0_valid, out1_valid, out0_ready, out1_ready;
  logic [63:0] out0_data, out1_data, rd_dout;
  logic CONFIG_VALID, CONFIG_READY, rd_dout_valid, rd_dout_ready;
  logic [31:0] CONFIG_START_ADDR, CONFIG_NBYTES;
  int checks = 0, errors = 0;
  int done_cnt[2] = '{0, 0};
  int beats[2] = '{0, 0};
  int cfg_cnt = 0;
  int grant_log[$];
  bit gaps = 0;

  dram_read_arbiter dut (
    .ACLK(ACLK), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_nbytes(req0_nbytes), .req1_nbytes(req1_nbytes),
    .done0(done0), .done1(done1),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready),
    .out0_data(out0_data), .out1_data(out1_data),
    .CONFIG_VALID(CONFIG_VALID), .CONFIG_READY(CONFIG_READY),
    .CONFIG_START_ADDR(CONFIG_START_ADDR), .CONFIG_NBYTES(CONFIG_NBYTES),
    .rd_dout_valid(rd_dout_valid), .rd_dout_ready(rd_dout_ready), .rd_dout(rd_dout)
  );

  initial ACLK = 0;
  always #5 ACLK = ~ACLK;

  function automatic logic [63:0] beat_data(input logic [31:0] a, input int i);
    logic [31:0] x;
    x = a + (32'(i) << 3);
    return {~x, x};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reader model: idle -> accept config -> emit nbytes/8 in-order beats -> idle
  int rd_rem, rd_rem_n, rd_cnt;
  logic [31:0] rd_base;
  assign rd_dout = beat_data(rd_base, rd_cnt);
  always @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      CONFIG_READY <= 1'b1;
      rd_dout_valid <= 1'b0;
      rd_rem <= 0;
      rd_cnt <= 0;
      rd_base <= '0;
    end else begin
      rd_rem_n = rd_rem;
      if (rd_dout_valid && rd_dout_ready) begin
        rd_rem_n = rd_rem_n - 1;
        rd_cnt <= rd_cnt + 1;
      end
      if (CONFIG_VALID && CONFIG_READY) begin
        rd_rem_n = int'(CONFIG_NBYTES >> 3);
        rd_base <= CONFIG_START_ADDR;
        rd_cnt <= 0;
        CONFIG_READY <= 1'b0;
      end else if (!CONFIG_READY && rd_rem_n == 0) CONFIG_READY <= 1'b1;
      rd_rem <= rd_rem_n;
      rd_dout_valid <= rd_rem_n != 0 &&
        ((rd_dout_valid && !rd_dout_ready) || !gaps || $urandom_range(0, 3) != 0);
    end
  end

  // scoreboard: one job at a time, arbitration and beat order derived from the job rules
  bit act = 0, cfg_pend = 0, who = 0, rr_last = 1, idle_m, rdy_sel;
  logic [1:0] done_pend = 2'b00, vin, eg;
  int idx = 0;
  logic [31:0] cur_addr, cur_nb;
  always @(negedge ACLK) begin
    if (!rst_n) begin
      check("reset_outputs", {req1_ready, req0_ready, done1, done0, out1_valid, out0_valid,
            rd_dout_ready, CONFIG_VALID, CONFIG_START_ADDR, CONFIG_NBYTES}, '0);
      act = 0; cfg_pend = 0; done_pend = 2'b00; rr_last = 1;
    end else begin
      idle_m = !act && !cfg_pend;
      check("done", {done1, done0}, done_pend);
      if (done0) done_cnt[0]++;
      if (done1) done_cnt[1]++;
      done_pend = 2'b00;
      check("cfg_valid", CONFIG_VALID, cfg_pend);
      if (cfg_pend) begin
        check("cfg_addr", CONFIG_START_ADDR, cur_addr);
        check("cfg_nbytes", CONFIG_NBYTES, cur_nb);
        cfg_cnt++;
      end
      rdy_sel = who ? out1_ready : out0_ready;
      check("route", {out1_valid, out0_valid, rd_dout_ready},
            act ? {who & rd_dout_valid, !who & rd_dout_valid, rdy_sel} : 3'b000);
      if (act && rd_dout_valid && rdy_sel) begin
        check("data", who ? out1_data : out0_data, beat_data(cur_addr, idx));
        idx++;
        beats[who]++;
        if (idx == int'(cur_nb >> 3)) begin
          act = 0;
          done_pend[who] = 1'b1;
        end
      end
      if (cfg_pend) begin
        act = 1;
        idx = 0;
      end
      cfg_pend = 0;
      vin = {req1_valid, req0_valid};
      eg = (idle_m && CONFIG_READY && vin != 2'b00) ?
           (vin == 2'b11 ? (rr_last ? 2'b01 : 2'b10) : vin) : 2'b00;
      check("grant", {req1_ready, req0_ready}, eg);
      if (eg != 2'b00) begin
        who = eg[1];
        rr_last = who;
        grant_log.push_back(int'(who));
        cur_addr = who ? req1_addr : req0_addr;
        cur_nb = (who ? req1_nbytes : req0_nbytes) & ~32'd127;
        if (cur_nb == 0) done_pend[who] = 1'b1;
        else cfg_pend = 1;
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic submit(input bit w, input logic [31:0] a, input logic [31:0] n);
    logic got = 0;
    if (w) begin req1_valid = 1; req1_addr = a; req1_nbytes = n; end
    else begin req0_valid = 1; req0_addr = a; req0_nbytes = n; end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge ACLK);
      got = w ? req1_ready : req0_ready;
    end
    check("accept", got, 1);
    tick();
    if (w) req1_valid = 0;
    else req0_valid = 0;
  endtask

  task automatic wait_done(input bit w, input int target, input bit tog);
    for (int i = 0; i < 3000 && done_cnt[w] < target; i++) begin
      tick();
      out0_ready = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      out1_ready = tog ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check("done_wait", done_cnt[w] >= target, 1);
    out0_ready = 1;
    out1_ready = 1;
    tick();
  endtask

  int b0, b1, c0, d0, d1, g;
  logic [31:0] nb;
  bit w;
  logic [3:0] order;
  initial begin
    rst_n = 0;
    req0_valid = 0; req1_valid = 0;
    req0_addr = 0; req1_addr = 0; req0_nbytes = 0; req1_nbytes = 0;
    out0_ready = 1; out1_ready = 1;
    repeat (3) tick();
    check("reset_state", {req1_ready, req0_ready, done1, done0, out1_valid, out0_valid,
          rd_dout_ready, CONFIG_VALID, CONFIG_START_ADDR, CONFIG_NBYTES}, '0);
    rst_n = 1;
    tick();
    // single 256 B job on requester 0
    b0 = beats[0]; b1 = beats[1]; c0 = cfg_cnt; d0 = done_cnt[0];
    submit(0, 32'h1000, 256);
    wait_done(0, d0 + 1, 0);
    check("t1_beats0", beats[0] - b0, 32);
    check("t1_beats1", beats[1] - b1, 0);
    check("t1_cfg", cfg_cnt - c0, 1);
    check("t1_done0", done_cnt[0] - d0, 1);
    // 200 B rounds down to one burst
    b1 = beats[1]; d1 = done_cnt[1];
    submit(1, 32'h2000, 200);
    wait_done(1, d1 + 1, 0);
    check("t3_beats1", beats[1] - b1, 16);
    // both held: round robin 0,1,0,1
    b0 = beats[0]; b1 = beats[1]; d0 = done_cnt[0]; d1 = done_cnt[1]; g = grant_log.size();
    req0_addr = 32'h3000; req0_nbytes = 128; req1_addr = 32'h3800; req1_nbytes = 128;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 400 && grant_log.size() < g + 4; i++) tick();
    req0_valid = 0; req1_valid = 0;
    check("t2_grants", grant_log.size() - g, 4);
    if (grant_log.size() >= g + 4) begin
      for (int k = 0; k < 4; k++) order[k] = grant_log[g + k][0];
      check("t2_order", order, 4'b1010);
    end
    wait_done(0, d0 + 2, 0);
    wait_done(1, d1 + 2, 0);
    check("t2_beats0", beats[0] - b0, 32);
    check("t2_beats1", beats[1] - b1, 32);
    // zero-length job: done without CONFIG
    b0 = beats[0]; c0 = cfg_cnt; d0 = done_cnt[0];
    submit(0, 32'h4000, 100);
    wait_done(0, d0 + 1, 0);
    check("t4_cfg", cfg_cnt - c0, 0);
    check("t4_beats", beats[0] - b0, 0);
    // ready toggling and reader gaps
    gaps = 1;
    b0 = beats[0]; d0 = done_cnt[0];
    submit(0, 32'h5000, 128);
    wait_done(0, d0 + 1, 1);
    check("t5_beats", beats[0] - b0, 16);
    // random jobs
    for (int j = 0; j < 6; j++) begin
      w = 1'($urandom_range(0, 1));
      nb = 32'($urandom_range(0, 700));
      b0 = beats[w]; d0 = done_cnt[w];
      submit(w, $urandom & ~32'd7, nb);
      wait_done(w, d0 + 1, 1);
      check("t6_beats", beats[w] - b0, int'((nb & ~32'd127) >> 3));
    end
    // reset in the middle of a job
    gaps = 0;
    b0 = beats[0]; d0 = done_cnt[0];
    submit(0, 32'h8000, 256);
    for (int i = 0; i < 200 && beats[0] - b0 < 7; i++) tick();
    rst_n = 0;
    #1;
    check("t7_async_reset", {req1_ready, req0_ready, done1, done0, out1_valid, out0_valid,
          rd_dout_ready, CONFIG_VALID, CONFIG_START_ADDR, CONFIG_NBYTES}, '0);
    repeat (3) tick();
    check("t7_no_done", done_cnt[0] - d0, 0);
    rst_n = 1;
    tick();
    req0_addr = 32'h9000; req0_nbytes = 128; req1_addr = 32'hA000; req1_nbytes = 128;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 50 && !(req0_ready || req1_ready); i++) @(negedge ACLK);
    check("t7_first_grant", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_done(0, d0 + 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
